// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned CNT_BITS_DEF      = 16;
   localparam int unsigned REG_ADDR_BITS_DEF = 5;

   // Controller states: normal flow or frozen pipeline.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-status inputs and control outputs of the hazard controller.
// The pipeline side (master) drives the stage status and consumes enables and
// flushes. The controller side (slave) does the reverse. There is no handshake:
// every output is valid in every cycle.
interface pipe_hazard_ctrl_if
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CntBits     = CNT_BITS_DEF,
   parameter int unsigned RegAddrBits = REG_ADDR_BITS_DEF
);
   // ID stage sources
   logic [RegAddrBits-1:0] id_rs1;
   logic [RegAddrBits-1:0] id_rs2;
   logic                   id_uses_rs1;
   logic                   id_uses_rs2;
   // EX stage status
   logic                   ex_mem_read;
   logic [RegAddrBits-1:0] ex_rd;
   logic                   ex_branch_taken;
   // Freeze / resume requests
   logic                   halt_req;
   logic                   go;
   // Pipeline register controls
   logic                   pc_en;
   logic                   ifid_en;
   logic                   idex_en;
   logic                   ifid_flush;
   logic                   idex_flush;
   logic                   halted;
   // Statistics
   logic [CntBits-1:0]     stall_cnt;
   logic [CntBits-1:0]     flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
      output ex_mem_read, ex_rd, ex_branch_taken, halt_req, go,
      input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, halted,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
      input  ex_mem_read, ex_rd, ex_branch_taken, halt_req, go,
      output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, halted,
      output stall_cnt, flush_cnt
   );

endinterface : pipe_hazard_ctrl_if

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection: the ID instruction reads a register that the
// load currently in EX will write. Register 0 is never a hazard.
module hazard_detect
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned RegAddrBits = REG_ADDR_BITS_DEF
) (
   input  logic [RegAddrBits-1:0] i_id_rs1,
   input  logic [RegAddrBits-1:0] i_id_rs2,
   input  logic                   i_id_uses_rs1,
   input  logic                   i_id_uses_rs2,
   input  logic                   i_ex_mem_read,
   input  logic [RegAddrBits-1:0] i_ex_rd,
   output logic                   o_load_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   // Per-source match against the EX destination, gated by actual use.
   always_comb begin
      w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
      w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
      o_load_use = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
   end

endmodule : hazard_detect

// File: rtl/pipe_hazard_ctrl_sat_inc.sv
// Saturating increment: next value of a counter that sticks at all-ones.
// The register itself lives in the caller.
module sat_inc #(
   parameter int unsigned Width = 16
) (
   input  logic [Width-1:0] i_val,
   input  logic             i_inc,
   output logic [Width-1:0] o_val
);

   // Add one only when requested and not already at the ceiling.
   always_comb begin
      o_val = i_val;
      if (i_inc && (i_val != '1)) begin
         o_val = i_val + Width'(1);
      end
   end

endmodule : sat_inc

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls on load-use, flushes on taken branch,
// freezes on halt request, and counts stall/flush cycles.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CntBits     = CNT_BITS_DEF,
   parameter int unsigned RegAddrBits = REG_ADDR_BITS_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   pipe_hazard_ctrl_if.slave  io_hz,
   output state_t             o_state
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CntBits-1:0] r_stall_cnt;
   logic [CntBits-1:0] r_flush_cnt;
   logic [CntBits-1:0] w_stall_cnt_nxt;
   logic [CntBits-1:0] w_flush_cnt_nxt;
   logic               w_load_use;
   logic               w_stall_ev;
   logic               w_flush_ev;
   logic               w_pc_en;
   logic               w_ifid_en;
   logic               w_idex_en;
   logic               w_ifid_flush;
   logic               w_idex_flush;

   hazard_detect #(
      .RegAddrBits (RegAddrBits)
   ) u_hazard_detect (
      .i_id_rs1      (io_hz.id_rs1),
      .i_id_rs2      (io_hz.id_rs2),
      .i_id_uses_rs1 (io_hz.id_uses_rs1),
      .i_id_uses_rs2 (io_hz.id_uses_rs2),
      .i_ex_mem_read (io_hz.ex_mem_read),
      .i_ex_rd       (io_hz.ex_rd),
      .o_load_use    (w_load_use)
   );

   sat_inc #(
      .Width (CntBits)
   ) u_stall_inc (
      .i_val (r_stall_cnt),
      .i_inc (w_stall_ev),
      .o_val (w_stall_cnt_nxt)
   );

   sat_inc #(
      .Width (CntBits)
   ) u_flush_inc (
      .i_val (r_flush_cnt),
      .i_inc (w_flush_ev),
      .o_val (w_flush_cnt_nxt)
   );

   // State register; reset always lands in RUN, even from HALT.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and Mealy pipeline controls. Priority in RUN:
   // halt request, then taken branch, then load-use.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_en    = 1'b0;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_stall_ev   = 1'b0;
      w_flush_ev   = 1'b0;
      if (i_rst) begin
         // Hold the PC and clear both pipeline registers while resetting.
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (io_hz.halt_req) begin
                  w_state_nxt = ST_HALT;
               end else if (io_hz.ex_branch_taken) begin
                  w_pc_en      = 1'b1;
                  w_ifid_en    = 1'b1;
                  w_idex_en    = 1'b1;
                  w_ifid_flush = 1'b1;
                  w_idex_flush = 1'b1;
                  w_flush_ev   = 1'b1;
               end else if (w_load_use) begin
                  // Hold PC and IF/ID, inject a bubble into ID/EX.
                  w_idex_en    = 1'b1;
                  w_idex_flush = 1'b1;
                  w_stall_ev   = 1'b1;
               end else begin
                  w_pc_en   = 1'b1;
                  w_ifid_en = 1'b1;
                  w_idex_en = 1'b1;
               end
            end
            ST_HALT: begin
               // A simultaneous halt request keeps the pipeline frozen.
               if (io_hz.go && !io_hz.halt_req) begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   // Statistics counters; events are already suppressed in HALT and halt cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_stall_cnt <= w_stall_cnt_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   assign io_hz.pc_en      = w_pc_en;
   assign io_hz.ifid_en    = w_ifid_en;
   assign io_hz.idex_en    = w_idex_en;
   assign io_hz.ifid_flush = w_ifid_flush;
   assign io_hz.idex_flush = w_idex_flush;
   assign io_hz.halted     = (r_state == ST_HALT) && !i_rst;
   assign io_hz.stall_cnt  = r_stall_cnt;
   assign io_hz.flush_cnt  = r_flush_cnt;
   assign o_state          = r_state;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. The driver applies one input vector per
// cycle and, when the cycle is to be checked, queues the hand-computed outputs.
// A monitor on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int unsigned CW = 16;
   localparam int unsigned AW = 5;
   localparam int unsigned VW = 6 + 2 * CW;

   // Control field order: {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, halted}
   localparam logic [5:0] C_RST   = 6'b000110;
   localparam logic [5:0] C_IDLE  = 6'b111000;
   localparam logic [5:0] C_STALL = 6'b001010;
   localparam logic [5:0] C_FLUSH = 6'b111110;
   localparam logic [5:0] C_HREQ  = 6'b000000;
   localparam logic [5:0] C_HALT  = 6'b000001;

   logic   clk;
   logic   rst;
   state_t dbg_state;

   logic [VW-1:0] exp_q[$];
   string         name_q[$];
   int            checks;
   int            failures;

   pipe_hazard_ctrl_if #(.CntBits(CW), .RegAddrBits(AW)) hz ();

   pipe_hazard_ctrl #(
      .CntBits     (CW),
      .RegAddrBits (AW)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .io_hz   (hz),
      .o_state (dbg_state)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, queue depth=%0d", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   // Driver: apply one cycle of inputs shortly after the rising edge.
   task automatic apply(input logic r, input logic mr, input logic [AW-1:0] rd,
                        input logic [AW-1:0] r1, input logic u1,
                        input logic [AW-1:0] r2, input logic u2,
                        input logic br, input logic hr, input logic g);
      @(posedge clk);
      #1;
      rst                = r;
      hz.ex_mem_read     = mr;
      hz.ex_rd           = rd;
      hz.id_rs1          = r1;
      hz.id_uses_rs1     = u1;
      hz.id_rs2          = r2;
      hz.id_uses_rs2     = u2;
      hz.ex_branch_taken = br;
      hz.halt_req        = hr;
      hz.go              = g;
   endtask

   task automatic expect_out(input string nm, input logic [5:0] ctl,
                             input logic [CW-1:0] sc, input logic [CW-1:0] fc);
      exp_q.push_back({ctl, sc, fc});
      name_q.push_back(nm);
   endtask

   task automatic idle();
      apply(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic stall_rs1_5();
      apply(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [VW-1:0] act;
      logic [VW-1:0] e;
      string         nm;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.ifid_flush, hz.idex_flush,
                hz.halted, hz.stall_cnt, hz.flush_cnt};
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL %s: got ctl=%b stall=%h flush=%h, expected ctl=%b stall=%h flush=%h",
                     nm, act[VW-1 -: 6], act[2*CW-1 -: CW], act[CW-1:0],
                     e[VW-1 -: 6], e[2*CW-1 -: CW], e[CW-1:0]);
         end
      end
   end

   // Stimulus
   initial begin
      checks             = 0;
      failures           = 0;
      rst                = 1'b1;
      hz.ex_mem_read     = 1'b0;
      hz.ex_rd           = '0;
      hz.id_rs1          = '0;
      hz.id_rs2          = '0;
      hz.id_uses_rs1     = 1'b0;
      hz.id_uses_rs2     = 1'b0;
      hz.ex_branch_taken = 1'b0;
      hz.halt_req        = 1'b0;
      hz.go              = 1'b0;

      apply(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("reset", C_RST, 16'h0000, 16'h0000);

      idle();        expect_out("idle_after_reset", C_IDLE, 16'h0000, 16'h0000);
      stall_rs1_5(); expect_out("load_use_rs1", C_STALL, 16'h0000, 16'h0000);
      idle();        expect_out("stall_cnt_1", C_IDLE, 16'h0001, 16'h0000);
      apply(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("rd_zero_no_stall", C_IDLE, 16'h0001, 16'h0000);
      idle();        expect_out("stall_cnt_held", C_IDLE, 16'h0001, 16'h0000);
      apply(1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("load_use_rs2", C_STALL, 16'h0001, 16'h0000);
      apply(1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("unused_src_no_stall", C_IDLE, 16'h0002, 16'h0000);
      apply(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("branch_over_load_use", C_FLUSH, 16'h0002, 16'h0000);
      apply(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("branch_only", C_FLUSH, 16'h0002, 16'h0001);
      idle();        expect_out("flush_cnt_2", C_IDLE, 16'h0002, 16'h0002);

      // Halt request wins over branch and load-use; counters frozen.
      apply(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_out("halt_req_priority", C_HREQ, 16'h0002, 16'h0002);
      idle();        expect_out("halted_1", C_HALT, 16'h0002, 16'h0002);
      apply(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_out("halted_go_and_req", C_HALT, 16'h0002, 16'h0002);
      apply(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("halted_events_ignored", C_HALT, 16'h0002, 16'h0002);
      apply(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("halted_go", C_HALT, 16'h0002, 16'h0002);
      idle();        expect_out("run_after_go", C_IDLE, 16'h0002, 16'h0002);

      // Drive the stall counter from 2 up to 0xFFFE without checking each cycle.
      for (int i = 0; i < 65532; i++) begin
         stall_rs1_5();
      end
      stall_rs1_5(); expect_out("stall_cnt_fffe", C_STALL, 16'hFFFE, 16'h0002);
      stall_rs1_5(); expect_out("stall_cnt_ffff", C_STALL, 16'hFFFF, 16'h0002);
      stall_rs1_5(); expect_out("stall_cnt_sat", C_STALL, 16'hFFFF, 16'h0002);
      idle();        expect_out("stall_cnt_sat_held", C_IDLE, 16'hFFFF, 16'h0002);

      // Reset while halted with nonzero counters.
      apply(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("halt_req_2", C_HREQ, 16'hFFFF, 16'h0002);
      idle();        expect_out("halted_2", C_HALT, 16'hFFFF, 16'h0002);
      apply(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("reset_in_halt", C_RST, 16'hFFFF, 16'h0002);
      idle();        expect_out("run_after_reset", C_IDLE, 16'h0000, 16'h0000);

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CntBits, default 16: width of the stall and flush statistics counters.
REQ-002 Parameter RegAddrBits, default 5: register-index width.
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset, sampled on the rising Clock edge.
REQ-005 IdRs1, IdRs2  in  RegAddrBits each  source indices of the instruction in the ID stage.
REQ-006 IdUsesRs1, IdUsesRs2  in  1 each  ID instruction reads Rs1/Rs2.
REQ-007 ExMemRead  in  1  EX-stage instruction is a load.
REQ-008 ExRd  in  RegAddrBits  EX-stage destination index.
REQ-009 ExBranchTaken  in  1  EX-stage branch/jump resolved taken.
REQ-010 HaltReq  in  1  request to freeze the pipeline (ecall/debug).
REQ-011 Go  in  1  resume request while halted.
REQ-012 PcEn, IfIdEn, IdExEn  out  1 each  ClockEnable for the PC, IF/ID and ID/EX pipeline registers.
REQ-013 IfIdFlush, IdExFlush  out  1 each  synchronous clear for the IF/ID and ID/EX pipeline registers.
REQ-014 Halted  out  1  controller is in HALT.
REQ-015 StallCnt, FlushCnt  out  CntBits each  statistics counters.

Function
REQ-016 The controller SHALL have exactly two states, RUN and HALT; enables/flushes are Mealy outputs of state and current inputs.
REQ-017 LoadUse SHALL be ExMemRead & (ExRd!=0) & ((IdUsesRs1 & IdRs1==ExRd) | (IdUsesRs2 & IdRs2==ExRd)).
REQ-018 In RUN with no event, PcEn=IfIdEn=IdExEn=1 and both flushes 0.
REQ-019 In RUN with LoadUse and not ExBranchTaken: PcEn=0, IfIdEn=0, IdExEn=1, IdExFlush=1, IfIdFlush=0 (one bubble per cycle LoadUse holds).
REQ-020 In RUN with ExBranchTaken: all enables 1, IfIdFlush=1, IdExFlush=1; branch SHALL take priority over LoadUse.
REQ-021 In RUN with HaltReq: all enables 0, flushes 0, next state HALT; HaltReq SHALL take priority over branch and LoadUse that cycle.
REQ-022 In HALT: all enables 0, flushes 0, Halted=1; Go SHALL return to RUN next cycle; HaltReq and Go both high in HALT SHALL stay HALT.
REQ-023 Halted SHALL be 1 only in HALT (registered, not combinational on HaltReq).
REQ-024 StallCnt SHALL increment by 1 in each cycle REQ-019 applies; FlushCnt in each cycle REQ-020 applies.
REQ-025 Both counters SHALL saturate at all-ones and never wrap.
REQ-026 No counter SHALL change in HALT or in a HaltReq cycle.

Reset
REQ-027 Reset SHALL force state RUN, StallCnt=0, FlushCnt=0 on the next rising edge, overriding every other input.
REQ-028 During a Reset cycle, outputs SHALL be PcEn=IfIdEn=IdExEn=0, IfIdFlush=IdExFlush=1, Halted=0.
REQ-029 Reset asserted while HALT SHALL leave HALT without Go.

Structure
REQ-030 A shared package SHALL hold the RUN/HALT state encoding and the default CntBits/RegAddrBits constants.
REQ-031 Hazard comparison (REQ-017) SHALL be a sub-module hazard_detect; state register and counters stay in pipe_hazard_ctrl.
REQ-032 Counters SHALL use one parameterised saturating-increment construct instantiated twice.

Verification
REQ-033 ExMemRead=1, ExRd=5, IdRs1=5, IdUsesRs1=1 for one cycle -> PcEn=0, IfIdEn=0, IdExFlush=1; StallCnt 0->1.
REQ-034 Same as REQ-033 with ExRd=0 -> no stall, StallCnt stays 0.
REQ-035 LoadUse and ExBranchTaken together -> IfIdFlush=IdExFlush=1, PcEn=1; FlushCnt+1, StallCnt unchanged.
REQ-036 HaltReq one cycle, Go after 3 cycles -> Halted=1 for 3 cycles, enables 0 throughout, RUN on cycle after Go.
REQ-037 Preload StallCnt to 0xFFFE (force 65534 stalls), two more stalls -> 0xFFFF then 0xFFFF.
REQ-038 Reset asserted in HALT with counters nonzero -> next cycle RUN, Halted=0, counters 0.
